// File: rtl/axis_packetizer_pkg.sv
// Shared definitions for the byte-stream packetizer: FSM state encoding and
// the default sync byte that opens every packet.
package axis_packetizer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        DATA,
        SUM
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/axis_packetizer.sv
// Frames an upstream byte stream into SYNC / HEADER / payload / CHECKSUM packets
// on a registered output stream that moves one byte per cycle when unstalled.
module axis_packetizer
    import axis_packetizer_pkg::*;
#(
    parameter int unsigned PAYLOAD_LENGTH = 16,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       overflow,
    input  logic [7:0] idata,
    input  logic       ivalid,
    output logic       iready,
    output logic [7:0] odata,
    output logic       ovalid,
    input  logic       oready,
    output logic       busy
);

    localparam int unsigned COUNT_W = (PAYLOAD_LENGTH > 1) ? $clog2(PAYLOAD_LENGTH) : 1;
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(PAYLOAD_LENGTH - 1);

    state_t             state;
    logic [6:0]         seq;
    logic [7:0]         sum;
    logic [COUNT_W-1:0] count;
    logic               slot_free;

    // The output register can take a new byte when it is empty or being drained.
    assign slot_free = !ovalid || oready;
    assign iready    = (state == DATA) && slot_free;
    assign busy      = (state != IDLE) || ovalid;

    // NOTE: all state below updates with non-blocking assignments so every
    // branch sees the pre-edge values of state, sum, count and seq.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            odata  <= 8'h00;
            ovalid <= 1'b0;
            seq    <= 7'd0;
            sum    <= 8'h00;
            count  <= '0;
        end else if (slot_free) begin
            // Default empties the slot; every load below re-asserts ovalid.
            ovalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ivalid) begin
                        odata  <= SYNC_BYTE;
                        ovalid <= 1'b1;
                        state  <= HEAD;
                    end
                end
                HEAD: begin
                    odata  <= {overflow, seq};
                    ovalid <= 1'b1;
                    sum    <= {overflow, seq};
                    count  <= '0;
                    state  <= DATA;
                end
                DATA: begin
                    if (ivalid) begin
                        odata  <= idata;
                        ovalid <= 1'b1;
                        sum    <= sum + idata;
                        count  <= count + 1'b1;
                        if (count == LAST_COUNT) begin
                            state <= SUM;
                        end
                    end
                end
                SUM: begin
                    odata  <= -sum;
                    ovalid <= 1'b1;
                    seq    <= seq + 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/axis_packetizer.md
# axis_packetizer

Frames the byte stream coming out of the push-to-AXI-stream FIFO into fixed-length packets for a byte-oriented link such as a UART or USB bridge. Each packet carries a sync byte, a header with a sequence number and the upstream overflow flag, the payload, and a checksum. The block sits directly downstream of the push/FIFO stage. It consumes that stage's `odata`/`ovalid`/`oready` stream and its sticky `overflow` flag. Its output is a registered AXI stream that runs at one byte per cycle when not back-pressured.

## Interface
- `PAYLOAD_LENGTH`, default 16: payload bytes per packet; legal range 1..256.
- `SYNC_BYTE`, default 8'hA5: first byte of every packet.
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `overflow`  in  1  sticky overflow flag from the upstream push stage; sampled once per packet.
- `idata`  in  8  payload byte from upstream.
- `ivalid`  in  1  upstream byte valid.
- `iready`  out  1  payload byte accepted this cycle; combinational.
- `odata`  out  8  framed output byte; registered.
- `ovalid`  out  1  output byte valid; registered.
- `oready`  in  1  downstream accepts `odata`.
- `busy`  out  1  high when the state is not IDLE or `ovalid` is high.

## Operation
- Packet format: SYNC_BYTE, HEADER = {overflow, seq[6:0]}, PAYLOAD_LENGTH payload bytes, CHECKSUM.
- CHECKSUM is the two's-complement negation of the mod-256 sum of HEADER and all payload bytes. The sum of HEADER + payload + CHECKSUM is therefore 0 mod 256. SYNC is excluded from the sum.
- Output slot is free when `!ovalid || oready`. A byte is loaded into `odata` only when the slot is free.
- The FSM state names the next byte to load:
  - IDLE: when the slot is free and `ivalid`=1, load SYNC_BYTE and go to HEAD. The payload byte is not consumed yet.
  - HEAD: when the slot is free, load {overflow, seq}, set sum to the header value, clear count, go to DATA.
  - DATA: when the slot is free and `ivalid`=1, assert `iready`, load `idata`, add it to sum, increment count. After the byte where count = PAYLOAD_LENGTH-1, go to SUM.
  - SUM: when the slot is free, load -sum, increment seq (7-bit, wraps 127 to 0), go to IDLE.
- `iready` = (state==DATA) && slot free. It is never high in any other state.
- A packet is never started without upstream data; once started, DATA waits for `ivalid` indefinitely with no timeout and no padding.
- `overflow` is sampled only when HEADER is loaded. A flag that rises mid-packet appears in the next packet's header.
- The count register is wide enough to hold PAYLOAD_LENGTH-1. The sum register is 8 bits and wraps.

## Timing
- Reset values: `odata`=0, `ovalid`=0, state IDLE, seq=0, sum=0, count=0. Therefore `iready`=0 and `busy`=0.
- Reset asserted mid-packet drops the partial packet. After release, the first packet starts with SYNC and seq 0.
- Latency: `ivalid` high in IDLE at cycle t gives SYNC on `odata` at t+1, HEADER at t+2, and the first payload byte at t+3 (accepted by `iready` at t+2).
- With `ivalid` and `oready` held high, a packet occupies exactly PAYLOAD_LENGTH+3 consecutive output cycles. The next SYNC follows CHECKSUM with no gap (the IDLE load occurs in the cycle after the SUM load).
- While `ovalid`=1 and `oready`=0, `odata` and `ovalid` hold and `iready`=0.
- When `ovalid`=1 and `oready`=1 with a load pending, the new byte replaces the old one in the same edge, with no bubble.
- When `ivalid`=0 in DATA with the old byte accepted, `ovalid` drops to 0 on the next edge.

## Structure
- Shared package holds the FSM state encoding (IDLE, HEAD, DATA, SUM) and the default SYNC_BYTE constant.
- Single module with no sub-module. The output register and FSM are small enough to keep inline.
- Top-level integration wires `push_to_axis` `odata`/`ovalid`/`oready`/`overflow` directly to `idata`/`ivalid`/`iready`/`overflow`.

## Test plan
- PAYLOAD_LENGTH=4, `overflow`=0, input 01 02 03 04, `oready`=1 -> output A5 00 01 02 03 04 F6 on 7 consecutive cycles.
- Continue with input 10 20 30 40 -> A5 01 10 20 30 40 5F, with SYNC immediately after the previous F6.
- `overflow`=1 before the header load, input 00 00 00 00 -> header 80 (seq 0 after reset), checksum 80. An `overflow` rise mid-packet appears only in the next header.
- Random `oready` and `ivalid` gaps over 300 packets -> `odata` stable while stalled, every packet sums to 0 mod 256 excluding SYNC, and seq wraps 7F to 00.
- Reset asserted during DATA after 2 payload bytes -> `ovalid`=0 and `busy`=0 immediately. After release, the next packet carries header 00 with a correct checksum.
- PAYLOAD_LENGTH=1, input 05 -> A5 00 05 FB.
